// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional borrow-in port is enabled with SERSUB_BORROW_IN_EN.
package serial_sub_pkg;

  localparam int SERSUB_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtract.sv
// Combinational 1-bit full-subtract cell: {o_bo, o_d} = i_a - i_b - i_bin.
module full_subtract (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bo
);

  logic w_axb;

  assign w_axb = i_a ^ i_b;
  assign o_d   = w_axb ^ i_bin;
  assign o_bo  = (~i_a & i_b) | (~w_axb & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Define SERSUB_BORROW_IN_EN to add the borrow_in seed port.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERSUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERSUB_BORROW_IN_EN
  input  logic             borrow_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow_q;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;

  logic             w_d;
  logic             w_bo;
  logic             w_bin_seed;
  logic [WIDTH-1:0] w_sh_next;

`ifdef SERSUB_BORROW_IN_EN
  assign w_bin_seed = borrow_in;
`else
  assign w_bin_seed = 1'b0;
`endif

  full_subtract u_cell (
    .i_a   (r_a_sh[0]),
    .i_b   (r_b_sh[0]),
    .i_bin (r_borrow_q),
    .o_d   (w_d),
    .o_bo  (w_bo)
  );

  // The final bit must be included when publishing the result.
  assign w_sh_next = {w_d, r_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_sh         <= '0;
      r_cnt        <= '0;
      r_borrow_q   <= 1'b0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh     <= a;
            r_b_sh     <= b;
            r_borrow_q <= w_bin_seed;
            r_cnt      <= CNT_LAST;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_a_sh     <= r_a_sh >> 1;
          r_b_sh     <= r_b_sh >> 1;
          r_sh       <= w_sh_next;
          r_borrow_q <= w_bo;
          r_cnt      <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_diff       <= w_sh_next;
            r_borrow_out <= w_bo;
            r_state      <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic model.
// Honors SERSUB_BORROW_IN_EN for the borrow-in port.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
`ifdef SERSUB_BORROW_IN_EN
    .borrow_in  (bin),
`endif
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] ma,
                                       input logic [W-1:0] mb,
                                       input logic mbin);
    logic [W:0] t;
    logic       eff;
`ifdef SERSUB_BORROW_IN_EN
    eff = mbin;
`else
    eff = 1'b0;
    if (mbin) eff = 1'b0;
`endif
    t = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, eff};
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                       input logic tbin, input bit scr);
    logic [W:0] exp;
    int n;
    int nb;
    exp   = model(ta, tb2, tbin);
    a     = ta;
    b     = tb2;
    bin   = tbin;
    start = 1'b1;
    tick();
    start = 1'b0;
    n  = 0;
    nb = 0;
    while (!done && n < 50) begin
      if (busy) nb++;
      if (scr) begin
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
      end
      tick();
      n++;
    end
    if (busy) nb++;
    check("latency", n, W);
    check("diff", diff, exp[W-1:0]);
    check("borrow_out", borrow_out, exp[W]);
    tick();
    check("done_pulse", done, 0);
    check("busy_fall", busy, 0);
    check("busy_cycles", nb, W + 1);
  endtask

  initial begin
    logic [W:0] exp;
    logic [W-1:0] prev;
    int ndone;
    int last;
    int bad;
    int n;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bo", borrow_out, 0);
    rst = 1'b0;
    tick();

    do_op(8'h5A, 8'h23, 1'b0, 1'b0);
    check("v1_diff", diff, 8'h37);
    do_op(8'h10, 8'h20, 1'b0, 1'b0);
    check("v2_diff", diff, 8'hF0);
    check("v2_bo", borrow_out, 1);
`ifdef SERSUB_BORROW_IN_EN
    do_op(8'h00, 8'h00, 1'b1, 1'b0);
    check("v3_diff", diff, 8'hFF);
    check("v3_bo", borrow_out, 1);
`endif

    // start during SHIFT must be ignored
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        ndone++;
        check("ign_diff", diff, 8'h02);
        check("ign_bo", borrow_out, 0);
      end
      tick();
    end
    check("ign_ndone", ndone, 1);

    // asynchronous reset mid-operation
    a = 8'h9C; b = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_diff", diff, 0);
    check("arst_bo", borrow_out, 0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done) ndone++;
      tick();
    end
    check("arst_nodone", ndone, 0);
    do_op(8'h9C, 8'h11, 1'b0, 1'b0);

    // start held high: back-to-back results
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    ndone = 0;
    last  = -1;
    bad   = 0;
    prev  = diff;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (done) begin
        ndone++;
        check("held_diff", diff, 8'h7F);
        check("held_bo", borrow_out, 0);
        if (last >= 0) check("held_period", i - last, W + 2);
        last = i;
      end else if (diff !== prev) begin
        bad++;
      end
      prev = diff;
    end
    check("held_ndone", ndone, 3);
    check("held_stable", bad, 0);
    start = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check("held_drain", busy, 0);

    // random operands, scrambled during SHIFT
    for (int k = 0; k < 20; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbin;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      exp  = model(ra, rb, rbin);
      do_op(ra, rb, rbin, 1'b1);
      check("rnd_bo", borrow_out, exp[W]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
